// File: rtl/port_width_adapter_if.sv
// Valid/ready bundle between a producer, the width adapter and a consumer.
//   in_valid/in_ready/in_data      : producer side, NCH lanes of IN_W bits
//   out_valid/out_ready/out_data   : consumer side, NCH lanes of OUT_W bits
//   out_lost                       : per-lane truncation-loss flag, travels with out_data
//   loss_cnt                       : saturating count of accepted lossy beats
// The slave modport is the adapter's view; master is the environment's view.
interface port_width_adapter_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*IN_W-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*OUT_W-1:0] out_data;
  logic [NCH-1:0]       out_lost;
  logic [CNT_W-1:0]     loss_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lost, loss_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lost, loss_cnt
  );
endinterface

// File: rtl/port_width_adapter.sv
// Registered lane-width adapter. Each of NCH lanes is converted from IN_W to OUT_W bits
// (truncate, zero-extend or sign-extend) as it enters a 2-entry in-order skid buffer.
// Lanes whose truncation changed the value are flagged, and lossy beats are counted.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : port_width_adapter_if.slave (handshakes, data, loss flags, loss counter)
module port_width_adapter #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned OUT_W  = 4,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  port_width_adapter_if.slave bus
);

  logic [NCH*OUT_W-1:0] conv_data;
  logic [NCH-1:0]       conv_lost;

  // Per-lane conversion, applied before storage.
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic [IN_W-1:0] lane_in;
    assign lane_in = bus.in_data[k*IN_W +: IN_W];

    if (OUT_W < IN_W) begin : g_trunc
      assign conv_data[k*OUT_W +: OUT_W] = lane_in[OUT_W-1:0];
      if (SIGNED) begin : g_sloss
        // Signed value survives only if every dropped bit equals the new sign bit.
        assign conv_lost[k] = (lane_in[IN_W-1:OUT_W] != {(IN_W-OUT_W){lane_in[OUT_W-1]}});
      end else begin : g_uloss
        assign conv_lost[k] = |lane_in[IN_W-1:OUT_W];
      end
    end else if (OUT_W > IN_W) begin : g_ext
      logic ext_bit;
      assign ext_bit = SIGNED ? lane_in[IN_W-1] : 1'b0;
      assign conv_data[k*OUT_W +: OUT_W] = {{(OUT_W-IN_W){ext_bit}}, lane_in};
      assign conv_lost[k] = 1'b0;
    end else begin : g_pass
      assign conv_data[k*OUT_W +: OUT_W] = lane_in;
      assign conv_lost[k] = 1'b0;
    end
  end

  // Entry 0 is always the head; entry 1 holds the second beat when cnt==2.
  logic [1:0][NCH*OUT_W-1:0] data_q, data_d;
  logic [1:0][NCH-1:0]       lost_q, lost_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [CNT_W-1:0]          loss_cnt_q, loss_cnt_d;
  logic                      push, pop;

  assign bus.in_ready  = !rst && (cnt_q != 2'd2);
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = data_q[0];
  assign bus.out_lost  = lost_q[0];
  assign bus.loss_cnt  = loss_cnt_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    data_d     = data_q;
    lost_d     = lost_q;
    cnt_d      = cnt_q;
    loss_cnt_d = loss_cnt_q;
    case ({push, pop})
      2'b10: begin
        // cnt is 0 or 1 here, so its low bit selects the free slot.
        data_d[cnt_q[0]] = conv_data;
        lost_d[cnt_q[0]] = conv_lost;
        cnt_d            = cnt_q + 2'd1;
      end
      2'b01: begin
        data_d[0] = data_q[1];
        lost_d[0] = lost_q[1];
        cnt_d     = cnt_q - 2'd1;
      end
      2'b11: begin
        // Push needs cnt<2 and pop needs cnt>0, so cnt==1: replace the head.
        data_d[0] = conv_data;
        lost_d[0] = conv_lost;
      end
      default: ;
    endcase
    if (push && (|conv_lost) && (loss_cnt_q != {CNT_W{1'b1}})) begin
      loss_cnt_d = loss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      lost_q     <= '0;
      cnt_q      <= 2'd0;
      loss_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      lost_q     <= lost_d;
      cnt_q      <= cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

endmodule
